sram_arbiter: RTL and testbench

//  Two-requester arbiter and sequencer in front of the single-port sram controller.

---
 rtl/sram_arbiter.sv | 126 ++++++++++++
 tb/tb_sram_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter and sequencer in front of the single-port sram controller
// Optional SRAM_ARB_PRIO_A_EN: fixed priority to port A; default build is round-robin.
module sram_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_write,
  output logic              mem_write,
  output logic              mem_read,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data_read
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t            state, state_nxt;
  logic              grant_b;
  logic              we_q;
  logic [7:0]        wd_cnt;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
  logic              pick_b;
  logic              in_wait;
  logic              done;
  logic              abort;
  logic              finish;

`ifdef SRAM_ARB_PRIO_A_EN
  assign pick_b = !a_req;
`else
  logic last_grant_b;
  assign pick_b = b_req && (!a_req || !last_grant_b);
`endif

  assign in_wait = (state == WAIT_BUSY) || (state == WAIT_DONE);

  // Bypass: ready still high two cycles after the pulse means the controller finished without going busy.
  always_comb begin
    done = 1'b0;
    case (state)
      WAIT_BUSY: done = mem_ready && (wd_cnt >= 8'd2);
      WAIT_DONE: done = mem_ready;
      default:   done = 1'b0;
    endcase
  end

  assign abort  = in_wait && !done && (wd_cnt == TIMEOUT_C);
  assign finish = done || abort;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (a_req || b_req) state_nxt = ISSUE;
      ISSUE:     if (mem_ready) state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (finish)          state_nxt = IDLE;
        else if (!mem_ready) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: if (finish) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign a_ack   = finish && !grant_b;
  assign b_ack   = finish && grant_b;
  assign err     = abort;
  assign a_rdata = (a_ack && done && !we_q) ? mem_data_read : a_rdata_q;
  assign b_rdata = (b_ack && done && !we_q) ? mem_data_read : b_rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      grant_b        <= 1'b0;
      we_q           <= 1'b0;
      wd_cnt         <= 8'd0;
      mem_address    <= '0;
      mem_data_write <= '0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
      a_rdata_q      <= '0;
      b_rdata_q      <= '0;
`ifndef SRAM_ARB_PRIO_A_EN
      last_grant_b   <= 1'b1;
`endif
    end else begin
      state     <= state_nxt;
      mem_write <= (state == ISSUE) && mem_ready && we_q;
      mem_read  <= (state == ISSUE) && mem_ready && !we_q;
      if (state == IDLE && (a_req || b_req)) begin
        grant_b        <= pick_b;
        we_q           <= pick_b ? b_we : a_we;
        mem_address    <= pick_b ? b_addr : a_addr;
        mem_data_write <= pick_b ? b_wdata : a_wdata;
`ifndef SRAM_ARB_PRIO_A_EN
        last_grant_b   <= pick_b;
`endif
      end
      // Cleared while issuing so the count starts at zero in the pulse cycle.
      if (state == ISSUE)
        wd_cnt <= 8'd0;
      else if (in_wait)
        wd_cnt <= wd_cnt + 8'd1;
      if (done && !we_q && !grant_b) a_rdata_q <= mem_data_read;
      if (done && !we_q && grant_b)  b_rdata_q <= mem_data_read;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - randomized self-checking bench for sram_arbiter with a behavioural controller
module tb_sram_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int TO = 255;
`ifdef SRAM_ARB_PRIO_A_EN
  localparam bit PRIO_A = 1'b1;
`else
  localparam bit PRIO_A = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, b_ack, err;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_write, mem_data_read;
  logic          mem_write, mem_read, mem_ready;

  int checks = 0;
  int failures = 0;

  int busy_n = 1;
  bit stuck_arm = 1'b0;
  int ctl_cnt = 0;
  logic [DW-1:0] ctl_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] exp_rd [2];

  int pulse_cnt = 0;
  int overlap_cnt = 0;
  int err_cnt = 0;
  bit last_pwe;
  logic [AW-1:0] last_paddr;
  logic [DW-1:0] last_pdata;
  int ack_log[$];

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .err(err), .mem_address(mem_address), .mem_data_write(mem_data_write),
    .mem_write(mem_write), .mem_read(mem_read), .mem_ready(mem_ready), .mem_data_read(mem_data_read)
  );

  // Controller model plus bus monitor: busy for busy_n cycles after each pulse, or very long when stuck.
  initial begin
    bit pw, pr;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    mem_ready = 1'b1;
    mem_data_read = '0;
    forever begin
      @(negedge clk);
      pw = mem_write; pr = mem_read; pa = mem_address; pd = mem_data_write;
      if (pw || pr) begin pulse_cnt++; last_pwe = pw; last_paddr = pa; last_pdata = pd; end
      if (pw && pr) overlap_cnt++;
      if (a_ack && b_ack) overlap_cnt++;
      if (a_ack) ack_log.push_back(0);
      if (b_ack) ack_log.push_back(1);
      if (err) err_cnt++;
      @(posedge clk); #1;
      if (ctl_cnt > 0) ctl_cnt--;
      if (pw || pr) begin
        if (pw) ctl_mem[pa] = pd;
        else mem_data_read = ctl_mem.exists(pa) ? ctl_mem[pa] : '0;
        ctl_cnt = stuck_arm ? TO + 15 : busy_n;
      end
      mem_ready = (ctl_cnt == 0);
    end
  end

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return '0;
  endfunction

  // Called just after a rising edge; returns just after the edge following the ack, request still high.
  task automatic do_access(input bit port, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           output logic [DW-1:0] rd, output bit e, output int lat);
    if (port) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    lat = -1; rd = '0; e = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (port ? b_ack : a_ack) begin
        lat = i; rd = port ? b_rdata : a_rdata; e = err;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic release_req(input bit port);
    if (port) b_req = 1'b0; else a_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
  endtask

  task automatic test_reset();
    logic [2*AW+4*DW+4:0] outs;
    repeat (2) @(negedge clk);
    outs = {a_ack, b_ack, err, mem_write, mem_read, mem_address, mem_data_write, a_rdata, b_rdata};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    @(posedge clk); #1 reset_n = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    repeat (4) @(negedge clk);
    checks++;
    if (ack_log.size() != 0) begin failures++; $display("FAIL reset_no_ack: got %0d acks expected 0", ack_log.size()); end
    checks++;
    if (pulse_cnt != 0) begin failures++; $display("FAIL reset_no_pulse: got %0d pulses expected 0", pulse_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [DW-1:0] rd; bit e; int lat; int p0;
    busy_n = 2; p0 = pulse_cnt;
    do_access(0, 1'b1, 18'h0, 16'hAAAA, rd, e, lat);
    release_req(0);
    ref_mem[18'h0] = 16'hAAAA;
    checks++; if (pulse_cnt - p0 != 1) begin failures++; $display("FAIL wr_pulses: got %0d expected 1", pulse_cnt - p0); end
    checks++; if (last_pwe !== 1'b1) begin failures++; $display("FAIL wr_pulse_kind: got we=%0b expected 1", last_pwe); end
    checks++; if (last_paddr !== 18'h0) begin failures++; $display("FAIL wr_addr: got %h expected 0", last_paddr); end
    checks++; if (last_pdata !== 16'hAAAA) begin failures++; $display("FAIL wr_data: got %h expected aaaa", last_pdata); end
    checks++; if (lat != busy_n + 3) begin failures++; $display("FAIL wr_latency: got %0d expected %0d", lat, busy_n + 3); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL wr_err: got %0b expected 0", e); end
    busy_n = 3; p0 = pulse_cnt;
    do_access(0, 1'b0, 18'h0, 16'h0, rd, e, lat);
    release_req(0);
    exp_rd[0] = 16'hAAAA;
    checks++; if (rd !== 16'hAAAA) begin failures++; $display("FAIL rd_data: got %h expected aaaa", rd); end
    checks++; if (pulse_cnt - p0 != 1 || last_pwe !== 1'b0) begin failures++; $display("FAIL rd_pulse: got %0d pulses we=%0b expected 1 read", pulse_cnt - p0, last_pwe); end
    checks++; if (lat != busy_n + 3) begin failures++; $display("FAIL rd_latency: got %0d expected %0d", lat, busy_n + 3); end
  endtask

  task automatic test_random();
    logic [DW-1:0] rd, d; bit e; int lat; int p0; bit port, we; logic [AW-1:0] addr;
    for (int k = 0; k < 24; k++) begin
      port = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
      addr = AW'($urandom_range(0, 7)); d = DW'($urandom);
      busy_n = $urandom_range(1, 4); p0 = pulse_cnt;
      do_access(port, we, addr, d, rd, e, lat);
      release_req(port);
      if (we) ref_mem[addr] = d;
      else exp_rd[port] = ref_rd(addr);
      checks++; if (lat != busy_n + 3) begin failures++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", k, lat, busy_n + 3); end
      checks++; if (e !== 1'b0) begin failures++; $display("FAIL rand_err[%0d]: got %0b expected 0", k, e); end
      checks++; if (pulse_cnt - p0 != 1 || last_pwe !== we) begin failures++; $display("FAIL rand_pulse[%0d]: got %0d pulses we=%0b expected 1 we=%0b", k, pulse_cnt - p0, last_pwe, we); end
      checks++; if (rd !== exp_rd[port]) begin failures++; $display("FAIL rand_rdata[%0d]: got %h expected %h", k, rd, exp_rd[port]); end
    end
  endtask

  task automatic test_tie();
    logic [DW-1:0] rda, rdb; bit ea, eb; int la, lb; int base, ov0;
    do_reset();
    busy_n = 2; base = ack_log.size(); ov0 = overlap_cnt;
    fork
      begin do_access(0, 1'b0, 18'h1, 16'h0, rda, ea, la); release_req(0); end
      begin do_access(1, 1'b0, 18'h2, 16'h0, rdb, eb, lb); release_req(1); end
    join
    exp_rd[0] = ref_rd(18'h1); exp_rd[1] = ref_rd(18'h2);
    checks++; if (ack_log.size() - base != 2) begin failures++; $display("FAIL tie_ack_count: got %0d expected 2", ack_log.size() - base); end
    checks++; if (ack_log.size() - base >= 1 && ack_log[base] != 0) begin failures++; $display("FAIL tie_first: got port %0d expected 0", ack_log[base]); end
    checks++; if (overlap_cnt != ov0) begin failures++; $display("FAIL tie_overlap: got %0d expected %0d", overlap_cnt, ov0); end
    checks++; if (rda !== exp_rd[0]) begin failures++; $display("FAIL tie_a_rdata: got %h expected %h", rda, exp_rd[0]); end
    checks++; if (rdb !== exp_rd[1]) begin failures++; $display("FAIL tie_b_rdata: got %h expected %h", rdb, exp_rd[1]); end
  endtask

  task automatic test_alternate();
    int base, ov0, last, nxt;
    bit a_done;
    do_reset();
    busy_n = 1; base = ack_log.size(); ov0 = overlap_cnt; a_done = 1'b0;
    fork
      begin
        logic [DW-1:0] rda, da; bit ea; int la;
        for (int k = 0; k < 4; k++) begin
          da = DW'($urandom);
          do_access(0, 1'b1, AW'(16 + k), da, rda, ea, la);
          ref_mem[AW'(16 + k)] = da;
        end
        release_req(0);
        a_done = 1'b1;
      end
      begin
        logic [DW-1:0] rdb, db; bit eb; int lb;
        for (int k = 0; k < 8 && !a_done; k++) begin
          db = DW'($urandom);
          do_access(1, 1'b1, AW'(32 + k), db, rdb, eb, lb);
          ref_mem[AW'(32 + k)] = db;
        end
        release_req(1);
      end
    join
    last = 1;
    for (int k = 0; k < 4; k++) begin
      nxt = PRIO_A ? 0 : 1 - last;
      last = nxt;
      checks++;
      if (ack_log.size() <= base + k) begin failures++; $display("FAIL alt_grant[%0d]: got no ack expected port %0d", k, nxt); end
      else if (ack_log[base + k] != nxt) begin failures++; $display("FAIL alt_grant[%0d]: got port %0d expected %0d", k, ack_log[base + k], nxt); end
    end
    checks++; if (overlap_cnt != ov0) begin failures++; $display("FAIL alt_overlap: got %0d expected %0d", overlap_cnt, ov0); end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] rd; bit e; int lat; int e0;
    e0 = err_cnt; stuck_arm = 1'b1;
    do_access(0, 1'b0, 18'h3, 16'h0, rd, e, lat);
    release_req(0);
    stuck_arm = 1'b0;
    checks++; if (lat != TO + 2) begin failures++; $display("FAIL to_latency: got %0d expected %0d", lat, TO + 2); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL to_err: got %0b expected 1", e); end
    checks++; if (rd !== exp_rd[0]) begin failures++; $display("FAIL to_rdata_held: got %h expected %h", rd, exp_rd[0]); end
    checks++; if (err_cnt - e0 != 1) begin failures++; $display("FAIL to_err_pulses: got %0d expected 1", err_cnt - e0); end
    busy_n = 2;
    do_access(0, 1'b0, 18'h0, 16'h0, rd, e, lat);
    release_req(0);
    exp_rd[0] = ref_rd(18'h0);
    checks++; if (rd !== exp_rd[0] || e !== 1'b0) begin failures++; $display("FAIL to_recover: got %h err=%0b expected %h err=0", rd, e, exp_rd[0]); end
  endtask

  task automatic test_reset_mid();
    logic [2*AW+4*DW+4:0] outs;
    logic [DW-1:0] rd, d; bit e; int lat; int base;
    busy_n = 6; base = ack_log.size();
    a_req = 1'b1; a_we = 1'b0; a_addr = 18'h0;
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    outs = {a_ack, b_ack, err, mem_write, mem_read, mem_address, mem_data_write, a_rdata, b_rdata};
    checks++; if (outs !== '0) begin failures++; $display("FAIL mid_reset_outputs: got %h expected 0", outs); end
    a_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ack_log.size() != base) begin failures++; $display("FAIL mid_no_ack: got %0d acks expected 0", ack_log.size() - base); end
    @(posedge clk); #1;
    busy_n = 2; d = DW'($urandom);
    do_access(1, 1'b1, 18'h28, d, rd, e, lat);
    release_req(1);
    ref_mem[18'h28] = d;
    checks++; if (lat < 0 || e !== 1'b0) begin failures++; $display("FAIL mid_b_write: got lat=%0d err=%0b expected ack err=0", lat, e); end
    do_access(1, 1'b0, 18'h28, 16'h0, rd, e, lat);
    release_req(1);
    checks++; if (rd !== ref_rd(18'h28)) begin failures++; $display("FAIL mid_b_readback: got %h expected %h", rd, ref_rd(18'h28)); end
  endtask

  initial begin
    reset_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    test_reset();
    test_write_read();
    test_random();
    test_tie();
    test_alternate();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
